ddr_bank_timing_tracker: RTL
============================

// Module: ddr_bank_timing_tracker
//
// PURPOSE
// - Per-rank DDR timing-legality tracker. It turns the static DDR4 timing constants into a parametrised, sequential checker.
// - Tracks per-bank state and timing counters for ACT/RD/WR/PRE/REF, and publishes per-bank "command legal this cycle" masks.
// - Sits between a RankFSM scheduler and the PHY command path; one instance per rank.
// - Issued commands are checked. An illegal command raises a sticky error and is ignored.
//
// PARAMETERS
// - NUM_BG    4     bank groups per rank
// - NUM_BK    4     banks per bank group; NUM_BANK = NUM_BG*NUM_BK
// - CNT_W     9     timing counter width; every timing parameter must be < 2**CNT_W
// - T_RCD     16    ACT to RD/WR, same bank
// - T_RP      16    PRE to ACT/REF, same bank
// - T_RAS     39    ACT to PRE, same bank
// - T_RTP     9     RD to PRE, same bank
// - T_WRP     34    WR to PRE, same bank (tCWL+tBL+tWR)
// - T_CCDS    4     column to column, different bank group
// - T_CCDL    6     column to column, same bank group
// - T_RFC     256   REF to any ACT
// - T_REFI    8192  refresh interval; used only with REFRESH_TRACK_EN
//
// PORTS
// - clk         in   1                 clock
// - rst_n       in   1                 asynchronous active-low reset
// - cmd_valid   in   1                 a command is issued this cycle
// - cmd_type    in   3                 1=ACT 2=RD 3=WR 4=PRE 5=REF; all other codes are illegal
// - cmd_bank    in   $clog2(NUM_BANK)  flat bank index, {bankgroup,bank}
// - cmd_ap      in   1                 auto-precharge with RD/WR
// - act_ok      out  NUM_BANK          ACT legal per bank
// - rd_ok       out  NUM_BANK          RD legal per bank
// - wr_ok       out  NUM_BANK          WR legal per bank
// - pre_ok      out  NUM_BANK          PRE legal per bank
// - ref_ok      out  1                 REF legal
// - bank_open   out  NUM_BANK          bank in ACTIVE state
// - ref_busy    out  1                 tRFC window running
// - ref_due     out  1                 refresh owed (REFRESH_TRACK_EN only)
// - err_illegal out  1                 sticky; set by any illegal command
//
// BEHAVIOUR
// - Reset (async, from rst_n low):
//   - All banks go IDLE and all counters go to 0.
//   - Outputs: act_ok='1, ref_ok=1, rd_ok=wr_ok=pre_ok=bank_open=0, ref_busy=0, ref_due=0, err_illegal=0.
//   - A reset mid-operation discards all open rows and pending timing.
// - Per-bank FSM states: IDLE -> ACT -> ACTIVE -> PRE -> IDLE.
//   - ACT command: IDLE->ACTIVE; loads rcd_cnt=T_RCD-1 and ras_cnt=T_RAS-1.
//   - PRE command: ACTIVE->IDLE; loads rp_cnt=T_RP-1.
//   - RD/WR with cmd_ap=1: loads the same rp_cnt, offset by the pending rtp/wr counter (precharge is implied when pre_ok would go high).
// - Timing rule: a command at cycle N with constraint T makes the dependent command legal no earlier than cycle N+T.
// - Counters are loaded with T-1 and decrement, saturating at 0. A counter at 0 means its constraint is met.
// - Masks are combinational from registered state; a command at cycle N is reflected in the masks at N+1.
// - Per-bank conditions:
//   - act_ok[b] = IDLE & rp_cnt==0 & !ref_busy.
//   - rd_ok[b] = ACTIVE & rcd_cnt==0 & ccd_s_cnt==0 & ccd_l_cnt[bg(b)]==0.
//   - wr_ok[b] = same as rd_ok[b].
//   - pre_ok[b] = ACTIVE & ras_cnt==0 & rtp_cnt==0 & wrp_cnt==0.
// - Column commands:
//   - RD loads rtp_cnt=T_RTP-1; WR loads wrp_cnt=T_WRP-1. Both are per bank.
//   - Both load the global ccd_s_cnt=T_CCDS-1 and ccd_l_cnt[bg]=T_CCDL-1.
//   - A reload always wins over a decrement in the same cycle.
// - REF:
//   - ref_ok = all banks IDLE & all rp_cnt==0 & !ref_busy.
//   - REF loads rfc_cnt=T_RFC-1; ref_busy=(rfc_cnt!=0).
// - Illegal command (ok bit low, or bad type): state and counters are unchanged, and err_illegal is set the next cycle and held until reset.
// - cmd_valid=0 means a pure counter tick. At most one command per cycle.
//
// CONFIGURATION
// - REFRESH_TRACK_EN defined:
//   - A CNT_W-independent 16-bit refi_cnt loads T_REFI-1 on reset release and after each legal REF.
//   - ref_due is set when refi_cnt reaches 0 and cleared by a legal REF.
//   - While ref_due=1, act_ok is forced to 0 (refresh-first).
// - REFRESH_TRACK_EN undefined: no refi_cnt; ref_due is tied to 0; act_ok is not gated by refresh.
//
// TESTING
// - Reset, then ACT b0 at N -> rd_ok[0]=0 through N+15, =1 at N+16; bank_open[0]=1 at N+1.
// - ACT b0 at N, PRE b0 at N+10 -> err_illegal=1 at N+11; bank_open[0] stays 1; a PRE at N+39 is accepted.
// - RD b0 (bg0) at N -> rd_ok[1] (bg0) goes high at N+6; rd_ok[4] (bg1) goes high at N+4.
// - WR b2 at N -> pre_ok[2]=0 until N+34 (T_RAS already met); PRE at N+34 accepted; act_ok[2] high at N+50.
// - All banks idle, REF at N -> act_ok='0 and ref_busy=1 until N+255; act_ok='1 at N+256.
// - With REFRESH_TRACK_EN: idle 8192 cycles -> ref_due=1 and act_ok='0; REF -> ref_due=0 the next cycle.
// - rst_n pulsed low while banks are open -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/ddr_bank_timing_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ddr_bank_timing_tracker
// Description : Per-rank DDR timing-legality tracker. It keeps a per-bank
//               IDLE/ACTIVE state and saturating down-counters for the
//               ACT/RD/WR/PRE/REF timing constraints. It publishes
//               per-bank "command legal this cycle" masks. An issued command
//               that is not legal leaves all state untouched and sets a
//               sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   REFRESH_TRACK_EN - adds a 16-bit refresh-interval counter. It drives
//                      ref_due and blocks ACT while a refresh is owed.
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   cmd_valid    in   a command is issued this cycle
//   cmd_type     in   1=ACT 2=RD 3=WR 4=PRE 5=REF, other codes illegal
//   cmd_bank     in   flat bank index {bankgroup, bank}
//   cmd_ap       in   auto-precharge qualifier for RD/WR
//   act_ok       out  ACT legal, per bank
//   rd_ok        out  RD legal, per bank
//   wr_ok        out  WR legal, per bank
//   pre_ok       out  PRE legal, per bank
//   ref_ok       out  REF legal
//   bank_open    out  bank is ACTIVE, per bank
//   ref_busy     out  tRFC window running
//   ref_due      out  refresh owed (REFRESH_TRACK_EN only, else 0)
//   err_illegal  out  sticky illegal-command flag
// ============================================================================
module ddr_bank_timing_tracker #(
    parameter int NUM_BG = 4,
    parameter int NUM_BK = 4,
    parameter int CNT_W  = 9,
    parameter int T_RCD  = 16,
    parameter int T_RP   = 16,
    parameter int T_RAS  = 39,
    parameter int T_RTP  = 9,
    parameter int T_WRP  = 34,
    parameter int T_CCDS = 4,
    parameter int T_CCDL = 6,
    parameter int T_RFC  = 256,
    parameter int T_REFI = 8192
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    input  logic [2:0]                        cmd_type,
    input  logic [$clog2(NUM_BG*NUM_BK)-1:0]  cmd_bank,
    input  logic                              cmd_ap,
    output logic [NUM_BG*NUM_BK-1:0]          act_ok,
    output logic [NUM_BG*NUM_BK-1:0]          rd_ok,
    output logic [NUM_BG*NUM_BK-1:0]          wr_ok,
    output logic [NUM_BG*NUM_BK-1:0]          pre_ok,
    output logic                              ref_ok,
    output logic [NUM_BG*NUM_BK-1:0]          bank_open,
    output logic                              ref_busy,
    output logic                              ref_due,
    output logic                              err_illegal
);

    localparam int NUM_BANK = NUM_BG * NUM_BK;
    localparam int BANK_W   = $clog2(NUM_BANK);
    localparam int BK_W     = $clog2(NUM_BK);
    localparam int AP_W     = CNT_W + 1;

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Counters are loaded with T-1 so that a command at cycle N makes the
    // dependent command legal from cycle N+T.
    localparam logic [CNT_W-1:0] LD_RCD  = CNT_W'(T_RCD  - 1);
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP   - 1);
    localparam logic [CNT_W-1:0] LD_RAS  = CNT_W'(T_RAS  - 1);
    localparam logic [CNT_W-1:0] LD_RTP  = CNT_W'(T_RTP  - 1);
    localparam logic [CNT_W-1:0] LD_WRP  = CNT_W'(T_WRP  - 1);
    localparam logic [CNT_W-1:0] LD_CCDS = CNT_W'(T_CCDS - 1);
    localparam logic [CNT_W-1:0] LD_CCDL = CNT_W'(T_CCDL - 1);
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC  - 1);

    // Full (not minus one) RD/WR-to-PRE distances, used to place the
    // implied precharge of an auto-precharge column command.
    localparam logic [CNT_W-1:0] DLY_RTP = CNT_W'(T_RTP);
    localparam logic [CNT_W-1:0] DLY_WRP = CNT_W'(T_WRP);

    // Saturating decrement: a counter parked at 0 means "constraint met".
    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Command decode and legality
    // ------------------------------------------------------------------
    logic                 is_act, is_rd, is_wr, is_pre, is_ref;
    logic                 cmd_legal;
    logic                 col_legal;
    logic                 ref_legal;
    logic [BANK_W-1:0]    cmd_bg;
    logic [NUM_BANK-1:0]  rp_zero;
    logic [NUM_BG-1:0]    ccd_l_zero;
    logic                 ccd_s_zero;
    logic                 act_block;

    always_comb begin
        is_act    = (cmd_type == CMD_ACT);
        is_rd     = (cmd_type == CMD_RD);
        is_wr     = (cmd_type == CMD_WR);
        is_pre    = (cmd_type == CMD_PRE);
        is_ref    = (cmd_type == CMD_REF);
        cmd_legal = 1'b0;
        if (cmd_valid) begin
            case (cmd_type)
                CMD_ACT: cmd_legal = act_ok[cmd_bank];
                CMD_RD:  cmd_legal = rd_ok[cmd_bank];
                CMD_WR:  cmd_legal = wr_ok[cmd_bank];
                CMD_PRE: cmd_legal = pre_ok[cmd_bank];
                CMD_REF: cmd_legal = ref_ok;
                default: cmd_legal = 1'b0;
            endcase
        end
        col_legal = cmd_legal && (is_rd || is_wr);
        ref_legal = cmd_legal && is_ref;
    end

    assign cmd_bg = cmd_bank >> BK_W;

    // ------------------------------------------------------------------
    // Per-bank state machine and timing counters
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic [0:0]       state;
        logic [CNT_W-1:0] rcd_cnt;
        logic [CNT_W-1:0] ras_cnt;
        logic [CNT_W-1:0] rtp_cnt;
        logic [CNT_W-1:0] wrp_cnt;
        logic [CNT_W-1:0] rp_cnt;
        logic             hit;
        logic             ap_close;
        logic [CNT_W-1:0] ap_wait;
        logic [AP_W-1:0]  ap_sum;
        logic [CNT_W-1:0] ap_load;

        assign hit      = cmd_legal && (cmd_bank == BANK_W'(b));
        assign ap_close = hit && (is_rd || is_wr) && cmd_ap;

        // Auto-precharge closes the bank immediately, but the implied PRE
        // only happens once every PRE constraint would be met. That is the
        // latest of tRAS, any earlier RD/WR recovery, and this command's
        // own tRTP/tWRP. tRP is then counted from that point, so rp_cnt is
        // preloaded with the combined distance. It saturates if the sum
        // cannot be represented.
        always_comb begin
            ap_wait = is_wr ? DLY_WRP : DLY_RTP;
            if (ras_cnt > ap_wait) ap_wait = ras_cnt;
            if (rtp_cnt > ap_wait) ap_wait = rtp_cnt;
            if (wrp_cnt > ap_wait) ap_wait = wrp_cnt;
            ap_sum  = {1'b0, ap_wait} + AP_W'(T_RP - 1);
            ap_load = ap_sum[AP_W-1] ? {CNT_W{1'b1}} : ap_sum[CNT_W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                rcd_cnt <= '0;
                ras_cnt <= '0;
                rtp_cnt <= '0;
                wrp_cnt <= '0;
                rp_cnt  <= '0;
            end else begin
                rcd_cnt <= (hit && is_act) ? LD_RCD : dec(rcd_cnt);
                ras_cnt <= (hit && is_act) ? LD_RAS : dec(ras_cnt);
                rtp_cnt <= (hit && is_rd)  ? LD_RTP : dec(rtp_cnt);
                wrp_cnt <= (hit && is_wr)  ? LD_WRP : dec(wrp_cnt);

                if (hit && is_pre)
                    rp_cnt <= LD_RP;
                else if (ap_close)
                    rp_cnt <= ap_load;
                else
                    rp_cnt <= dec(rp_cnt);

                if (hit && is_act)
                    state <= ST_ACTIVE;
                else if ((hit && is_pre) || ap_close)
                    state <= ST_IDLE;
            end
        end

        assign bank_open[b] = (state == ST_ACTIVE);
        assign rp_zero[b]   = (rp_cnt == '0);
        assign act_ok[b]    = (state == ST_IDLE) && rp_zero[b] && !ref_busy && !act_block;
        assign rd_ok[b]     = (state == ST_ACTIVE) && (rcd_cnt == '0) && ccd_s_zero
                              && ccd_l_zero[b / NUM_BK];
        assign wr_ok[b]     = rd_ok[b];
        assign pre_ok[b]    = (state == ST_ACTIVE) && (ras_cnt == '0)
                              && (rtp_cnt == '0) && (wrp_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Column-to-column spacing: one short window across bank groups, one
    // long window per bank group
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ccd_s_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ccd_s_cnt <= '0;
        else
            ccd_s_cnt <= col_legal ? LD_CCDS : dec(ccd_s_cnt);
    end

    assign ccd_s_zero = (ccd_s_cnt == '0);

    for (genvar g = 0; g < NUM_BG; g++) begin : g_bg
        logic [CNT_W-1:0] ccd_l_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ccd_l_cnt <= '0;
            else if (col_legal && (cmd_bg == BANK_W'(g)))
                ccd_l_cnt <= LD_CCDL;
            else
                ccd_l_cnt <= dec(ccd_l_cnt);
        end

        assign ccd_l_zero[g] = (ccd_l_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Refresh cycle window and sticky error
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rfc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfc_cnt     <= '0;
            err_illegal <= 1'b0;
        end else begin
            rfc_cnt <= ref_legal ? LD_RFC : dec(rfc_cnt);
            if (cmd_valid && !cmd_legal)
                err_illegal <= 1'b1;
        end
    end

    assign ref_busy = (rfc_cnt != '0);
    assign ref_ok   = (~|bank_open) && (&rp_zero) && !ref_busy;

    // ------------------------------------------------------------------
    // Optional refresh-interval tracking
    // ------------------------------------------------------------------
`ifdef REFRESH_TRACK_EN
    logic [15:0] refi_cnt;

    // The reset value is the post-release load. The interval therefore
    // starts counting on the first clock after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            refi_cnt <= 16'(T_REFI - 1);
        else if (ref_legal)
            refi_cnt <= 16'(T_REFI - 1);
        else if (refi_cnt != 16'd0)
            refi_cnt <= refi_cnt - 16'd1;
    end

    // refi_cnt parks at 0 until a legal REF reloads it, so ref_due holds
    // exactly from expiry to the accepted REF. Banks are refresh-first.
    assign ref_due   = (refi_cnt == 16'd0);
    assign act_block = ref_due;
`else
    // T_REFI only matters with refresh tracking. It is folded in here so
    // both builds consume the same parameter list.
    localparam logic REFI_SET = (T_REFI > 0);
    assign ref_due   = 1'b0 & REFI_SET;
    assign act_block = 1'b0;
`endif

endmodule

`default_nettype wire
